// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisor helper, frame constants and FSM
// state encodings used by the receive and transmit sides of the link.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

   typedef enum logic [1:0] {
      WAIT_HI,
      WAIT_LO,
      HOLD
   } asm_state_t;

   function automatic int calc_div(input int clk_freq, input int br);
      return clk_freq / br;
   endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Command output port of the receiver: 16-bit command with valid/ready.
interface uart_cmd_rx_if;

   logic [15:0] cmd_out;
   logic        cmd_vld;
   logic        cmd_rdy;

   modport master (
      output cmd_out,
      output cmd_vld,
      input  cmd_rdy
   );

   modport slave (
      input  cmd_out,
      input  cmd_vld,
      output cmd_rdy
   );

endinterface

// File: rtl/uart_rx_byte.sv
// Single UART frame receiver: synchronizer, bit FSM, parity and stop checks.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int DIV       = 434,
   parameter int PARITY_EN = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       byte_done,
   output logic       err_parity,
   output logic       err_frame,
   output logic       idle
);

   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);

   rx_state_t     state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic          sync1;
   logic          sync2;
   logic          prev;
   logic          par_bit;
   logic          stop_q;
   logic          fin;
   logic          par_ok;

   assign par_ok = (PARITY_EN == 0) || (par_bit == ~^data);
   assign idle   = (state == RX_IDLE);

   // Outcome flags are registered one cycle after the stop sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1      <= 1'b1;
         sync2      <= 1'b1;
         prev       <= 1'b1;
         state      <= RX_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         data       <= '0;
         par_bit    <= 1'b0;
         stop_q     <= 1'b0;
         fin        <= 1'b0;
         byte_done  <= 1'b0;
         err_parity <= 1'b0;
         err_frame  <= 1'b0;
      end else begin
         sync1      <= rx;
         sync2      <= sync1;
         prev       <= sync2;
         fin        <= 1'b0;
         byte_done  <= fin & stop_q & par_ok;
         err_parity <= fin & ~par_ok;
         err_frame  <= fin & ~stop_q;
         unique case (state)
            RX_IDLE: begin
               if (prev && !sync2) begin
                  state <= RX_START;
                  cnt   <= '0;
               end
            end
            RX_START: begin
               if (cnt == CW'(HALF - 1)) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= sync2 ? RX_IDLE : RX_DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RX_DATA: begin
               if (cnt == CW'(DIV - 1)) begin
                  cnt     <= '0;
                  data    <= {sync2, data[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'(DATA_BITS - 1))
                     state <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RX_PARITY: begin
               if (cnt == CW'(DIV - 1)) begin
                  cnt     <= '0;
                  par_bit <= sync2;
                  state   <= RX_STOP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RX_STOP: begin
               if (cnt == CW'(DIV - 1)) begin
                  cnt    <= '0;
                  stop_q <= sync2;
                  fin    <= 1'b1;
                  state  <= sync2 ? RX_IDLE : RX_BREAK;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RX_BREAK: begin
               if (sync2)
                  state <= RX_IDLE;
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: pairs received bytes (high first) into 16-bit
// commands with an inter-byte timeout and valid/ready output.
module uart_cmd_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int BR           = 115200,
   parameter int PARITY_EN    = 1,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   uart_cmd_rx_if.master        cmd,
   output logic                 err_parity,
   output logic                 err_frame,
   output logic                 err_overrun
);

   localparam int DIV = calc_div(CLK_FREQ, BR);
   localparam int CW  = $clog2(DIV);
   localparam int TW  = $clog2(TIMEOUT_BITS + 1);

   asm_state_t    st;
   logic [7:0]    data;
   logic          byte_done;
   logic          idle;
   logic          hs;
   logic          bad;
   logic [CW-1:0] tick;
   logic [TW-1:0] tbits;

   uart_rx_byte #(
      .DIV       (DIV),
      .PARITY_EN (PARITY_EN)
   ) u_byte (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .data       (data),
      .byte_done  (byte_done),
      .err_parity (err_parity),
      .err_frame  (err_frame),
      .idle       (idle)
   );

   assign hs  = cmd.cmd_vld & cmd.cmd_rdy;
   assign bad = err_parity | err_frame;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st          <= WAIT_HI;
         cmd.cmd_out <= '0;
         cmd.cmd_vld <= 1'b0;
         err_overrun <= 1'b0;
         tick        <= '0;
         tbits       <= '0;
      end else begin
         err_overrun <= 1'b0;
         unique case (st)
            WAIT_HI: begin
               if (byte_done) begin
                  cmd.cmd_out[15:8] <= data;
                  st                <= WAIT_LO;
                  tick              <= '0;
                  tbits             <= '0;
               end
            end
            WAIT_LO: begin
               if (byte_done) begin
                  cmd.cmd_out[7:0] <= data;
                  cmd.cmd_vld      <= 1'b1;
                  st               <= HOLD;
               end else if (bad) begin
                  st <= WAIT_HI;
               end else if (tbits == TW'(TIMEOUT_BITS)) begin
                  st <= WAIT_HI;
               end else if (idle) begin
                  // Only line-idle time counts toward the timeout.
                  if (tick == CW'(DIV - 1)) begin
                     tick  <= '0;
                     tbits <= tbits + TW'(1);
                  end else begin
                     tick <= tick + CW'(1);
                  end
               end
            end
            HOLD: begin
               if (hs) begin
                  cmd.cmd_vld <= 1'b0;
                  if (byte_done) begin
                     cmd.cmd_out[15:8] <= data;
                     st                <= WAIT_LO;
                     tick              <= '0;
                     tbits             <= '0;
                  end else begin
                     st <= WAIT_HI;
                  end
               end else if (byte_done) begin
                  err_overrun <= 1'b1;
               end
            end
            default: st <= WAIT_HI;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx with a transaction-level command model.
module tb_uart_cmd_rx;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BR       = 100_000;
   localparam int DIV      = 16;
   localparam int TO_BITS  = 20;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rx    = 1'b1;
   logic err_parity;
   logic err_frame;
   logic err_overrun;

   uart_cmd_rx_if cif ();

   uart_cmd_rx #(
      .CLK_FREQ     (CLK_FREQ),
      .BR           (BR),
      .PARITY_EN    (1),
      .TIMEOUT_BITS (TO_BITS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx          (rx),
      .cmd         (cif),
      .err_parity  (err_parity),
      .err_frame   (err_frame),
      .err_overrun (err_overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   logic [15:0] exp_q[$];
   int          exp_par = 0;
   int          exp_frm = 0;
   int          exp_ovr = 0;
   bit          m_hi_valid = 0;
   bit          m_hold = 0;
   logic [7:0]  m_hi = '0;

   int          n_par = 0;
   int          n_frm = 0;
   int          n_ovr = 0;
   int          n_hs = 0;
   int          n_vld = 0;
   int          rise_cyc = 0;
   int          tx_start = 0;
   logic [15:0] last_cmd = '0;
   logic        prev_vld = 1'b0;
   logic        prev_rdy = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Byte-level view of the link: what each finished frame must produce.
   task automatic model_byte(input logic [7:0] d, input bit bad_par,
                             input bit bad_stop);
      if (bad_par) exp_par++;
      if (bad_stop) exp_frm++;
      if (bad_par || bad_stop) begin
         m_hi_valid = 0;
      end else if (m_hold) begin
         exp_ovr++;
      end else if (!m_hi_valid) begin
         m_hi       = d;
         m_hi_valid = 1;
      end else begin
         exp_q.push_back({m_hi, d});
         m_hi_valid = 0;
         m_hold     = (cif.cmd_rdy == 1'b0);
      end
   endtask

   task automatic wait_bits(input int n);
      repeat (n * DIV) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input bit bad_par = 0,
                       input bit bad_stop = 0);
      model_byte(d, bad_par, bad_stop);
      @(posedge clk);
      #1;
      tx_start = cyc;
      rx = 1'b0;
      wait_bits(1);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         wait_bits(1);
      end
      rx = ~(^d) ^ bad_par;
      wait_bits(1);
      rx = ~bad_stop;
      wait_bits(1);
      rx = 1'b1;
   endtask

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (prev_vld && !prev_rdy)
            check("vld_dropped", 32'(cif.cmd_vld), 32'd1);
         if (cif.cmd_vld) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_vld: got cmd_out %h expected none",
                        cif.cmd_out);
            end else begin
               check("cmd_out", 32'(cif.cmd_out), 32'(exp_q[0]));
            end
            n_vld++;
            if (!prev_vld) rise_cyc = cyc;
            if (cif.cmd_rdy) begin
               last_cmd = cif.cmd_out;
               n_hs++;
               if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
         end
         n_par += int'(err_parity);
         n_frm += int'(err_frame);
         n_ovr += int'(err_overrun);
         prev_vld = cif.cmd_vld;
         prev_rdy = cif.cmd_rdy;
      end else begin
         prev_vld = 1'b0;
         prev_rdy = 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      cif.cmd_rdy = 1'b1;
      rx          = 1'b1;
      rst_n       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_cmd_out", 32'(cif.cmd_out), 32'd0);
      check("rst_cmd_vld", 32'(cif.cmd_vld), 32'd0);
      check("rst_err_par", 32'(err_parity), 32'd0);
      check("rst_err_frm", 32'(err_frame), 32'd0);
      check("rst_err_ovr", 32'(err_overrun), 32'd0);

      // Basic pair, consumer always ready
      n_vld = 0;
      send(8'hA5);
      send(8'h3C);
      wait_bits(2);
      check("t1_cmd", 32'(last_cmd), 32'h0000_A53C);
      check("t1_hs", n_hs, 1);
      check("t1_vld_len", n_vld, 1);
      check("t1_latency", rise_cyc - tx_start, 173);
      check("t1_errs", n_par + n_frm + n_ovr, 0);

      // Parity error on the low byte discards the pair
      send(8'h12);
      send(8'h34, 1, 0);
      wait_bits(2);
      check("t2_par_cnt", n_par, 1);
      check("t2_par_model", n_par, exp_par);
      check("t2_no_cmd", n_hs, 1);
      send(8'h56);
      send(8'h78);
      wait_bits(2);
      check("t2_cmd", 32'(last_cmd), 32'h0000_5678);
      check("t2_hs", n_hs, 2);

      // Glitch shorter than half a bit, then a framing error
      @(posedge clk);
      #1;
      rx = 1'b0;
      repeat (DIV / 4) @(posedge clk);
      #1;
      rx = 1'b1;
      wait_bits(2);
      check("t3_glitch_err", n_par + n_frm, 1);
      check("t3_glitch_hs", n_hs, 2);
      send(8'h5A, 0, 1);
      wait_bits(2);
      check("t3_frm_cnt", n_frm, 1);
      check("t3_frm_model", n_frm, exp_frm);
      check("t3_par_cnt", n_par, exp_par);

      // Lone high byte times out
      send(8'h80);
      wait_bits(25);
      m_hi_valid = 0;
      send(8'h01);
      send(8'h02);
      wait_bits(2);
      check("t4_cmd", 32'(last_cmd), 32'h0000_0102);
      check("t4_hs", n_hs, 3);

      // Held command with two overrunning bytes
      cif.cmd_rdy = 1'b0;
      send(8'h11);
      send(8'h11);
      send(8'h22);
      send(8'h22);
      wait_bits(2);
      check("t5_vld", 32'(cif.cmd_vld), 32'd1);
      check("t5_held", 32'(cif.cmd_out), 32'h0000_1111);
      check("t5_ovr_cnt", n_ovr, 2);
      check("t5_ovr_model", n_ovr, exp_ovr);
      check("t5_hs_before", n_hs, 3);
      @(posedge clk);
      #1;
      cif.cmd_rdy = 1'b1;
      m_hold = 0;
      wait_bits(1);
      check("t5_hs_after", n_hs, 4);
      check("t5_cmd", 32'(last_cmd), 32'h0000_1111);
      check("t5_vld_low", 32'(cif.cmd_vld), 32'd0);

      // Reset in the middle of data bit 4
      @(posedge clk);
      #1;
      rx = 1'b0;
      wait_bits(1);
      for (int i = 0; i < 4; i++) begin
         rx = (8'hBE >> i) & 8'h01;
         wait_bits(1);
      end
      rx = 1'b1;
      repeat (DIV / 2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      rx    = 1'b1;
      m_hi_valid = 0;
      m_hold     = 0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("t6_rst_cmd", 32'(cif.cmd_out), 32'd0);
      check("t6_rst_vld", 32'(cif.cmd_vld), 32'd0);
      #1;
      rst_n = 1'b1;
      wait_bits(1);
      send(8'hBE);
      send(8'hEF);
      wait_bits(2);
      check("t6_cmd", 32'(last_cmd), 32'h0000_BEEF);
      check("t6_hs", n_hs, 5);

      check("end_queue", exp_q.size(), 0);
      check("end_par", n_par, exp_par);
      check("end_frm", n_frm, exp_frm);
      check("end_ovr", n_ovr, exp_ovr);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
